// File: rtl/job_dispatcher_if.sv
// Descriptor-FIFO and engine-side signals of the job dispatcher.
// The master modport is the dispatcher; the slave modport is the FIFO/engine side.
interface job_dispatcher_if #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 1024,
  parameter int PASID_WIDTH = 9
);
  logic                   dsc_ready_i;
  logic [DATA_WIDTH-1:0]  dsc_data_i;
  logic                   dsc_pull_o;
  logic [NUM_ENGINES-1:0] eng_valid_o;
  logic [NUM_ENGINES-1:0] eng_ready_i;
  logic [DATA_WIDTH-1:0]  eng_data_o;
  logic [PASID_WIDTH-1:0] eng_pasid_o;
  logic [NUM_ENGINES-1:0] eng_done_i;

  modport master (
    input  dsc_ready_i, dsc_data_i, eng_ready_i, eng_done_i,
    output dsc_pull_o, eng_valid_o, eng_data_o, eng_pasid_o
  );

  modport slave (
    output dsc_ready_i, dsc_data_i, eng_ready_i, eng_done_i,
    input  dsc_pull_o, eng_valid_o, eng_data_o, eng_pasid_o
  );
endinterface

// File: rtl/job_dispatcher.sv
// Pops one descriptor at a time and offers it round-robin to a free engine; pull->valid is 2 cycles,
// one descriptor per 3 cycles at best; an unaccepted offer holds the FSM in SEND with no further pulls.
module job_dispatcher #(
  parameter int NUM_ENGINES   = 4,
  parameter int ENG_SEL_WIDTH = 2,
  parameter int DATA_WIDTH    = 1024,
  parameter int PASID_WIDTH   = 9,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable_i,
  job_dispatcher_if.master       bus,
  output logic [NUM_ENGINES-1:0] busy_o,
  output logic                   idle_o,
  output logic [CNT_WIDTH-1:0]   dispatch_cnt_o,
  output logic [CNT_WIDTH-1:0]   done_cnt_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND} state_t;

  state_t                   r_state, w_next_state;
  logic [DATA_WIDTH-1:0]    r_desc;
  logic [ENG_SEL_WIDTH-1:0] r_sel;
  logic [ENG_SEL_WIDTH-1:0] r_rr_ptr;
  logic [NUM_ENGINES-1:0]   r_busy;
  logic [NUM_ENGINES-1:0]   r_valid;
  logic [CNT_WIDTH-1:0]     r_dispatch_cnt;
  logic [CNT_WIDTH-1:0]     r_done_cnt;
  logic                     r_err;

  logic                     w_pull;
  logic                     w_hs;
  logic                     w_found;
  logic [ENG_SEL_WIDTH-1:0] w_free_idx;
  logic [NUM_ENGINES-1:0]   w_done_ok;
  logic [NUM_ENGINES-1:0]   w_done_bad;
  logic [NUM_ENGINES-1:0]   w_busy_nxt;
  logic [CNT_WIDTH-1:0]     w_done_inc;

  // Round-robin scan starting at r_rr_ptr; uses registered busy, so same-cycle dones are not seen.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_free_idx = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_ENGINES;
      if (!w_found && !r_busy[idx]) begin
        w_found    = 1'b1;
        w_free_idx = ENG_SEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pull       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i && bus.dsc_ready_i) begin
          w_pull       = 1'b1;
          w_next_state = S_ARB;
        end
      end
      S_ARB:   if (w_found) w_next_state = S_SEND;
      S_SEND:  if (w_hs) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_hs = (r_state == S_SEND) && bus.eng_ready_i[r_sel];

  // A done on the engine being handed a job is flagged as an error; the handshake still sets busy.
  always_comb begin
    w_done_ok  = bus.eng_done_i & r_busy;
    w_done_bad = bus.eng_done_i & ~r_busy;
    w_busy_nxt = r_busy & ~bus.eng_done_i;
    if (w_hs) w_busy_nxt = w_busy_nxt | (NUM_ENGINES'(1) << r_sel);
    w_done_inc = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (w_done_ok[k]) w_done_inc = w_done_inc + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_desc         <= '0;
      r_sel          <= '0;
      r_rr_ptr       <= '0;
      r_busy         <= '0;
      r_valid        <= '0;
      r_dispatch_cnt <= '0;
      r_done_cnt     <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_pull) r_desc <= bus.dsc_data_i;
      if (r_state == S_ARB && w_found) begin
        r_sel   <= w_free_idx;
        r_valid <= NUM_ENGINES'(1) << w_free_idx;
      end
      if (w_hs) begin
        r_valid        <= '0;
        r_rr_ptr       <= ENG_SEL_WIDTH'((int'(r_sel) + 1) % NUM_ENGINES);
        r_dispatch_cnt <= r_dispatch_cnt + CNT_WIDTH'(1);
      end
      r_busy     <= w_busy_nxt;
      r_done_cnt <= r_done_cnt + w_done_inc;
      if (|w_done_bad) r_err <= 1'b1;
    end
  end

  assign bus.dsc_pull_o  = w_pull;
  assign bus.eng_valid_o = r_valid;
  assign bus.eng_data_o  = r_desc;
  assign bus.eng_pasid_o = r_desc[992+PASID_WIDTH-1:992];
  assign busy_o          = r_busy;
  assign idle_o          = (r_state == S_IDLE) && (r_busy == '0);
  assign dispatch_cnt_o  = r_dispatch_cnt;
  assign done_cnt_o      = r_done_cnt;
  assign err_o           = r_err;

endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher: round-robin dispatch, stalls, done handling, wrap and async reset.
module tb_job_dispatcher;
  logic        clk = 1'b0;
  logic        resetn;
  logic        enable_i;
  logic [3:0]  busy_o;
  logic        idle_o;
  logic [31:0] dispatch_cnt_o;
  logic [31:0] done_cnt_o;
  logic        err_o;
  int          n_assert = 0;
  int          n_fail   = 0;

  job_dispatcher_if #(.NUM_ENGINES(4), .DATA_WIDTH(1024), .PASID_WIDTH(9)) bus ();

  job_dispatcher dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable_i       (enable_i),
    .bus            (bus),
    .busy_o         (busy_o),
    .idle_o         (idle_o),
    .dispatch_cnt_o (dispatch_cnt_o),
    .done_cnt_o     (done_cnt_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1023:0] desc(input int p);
    logic [1023:0] d;
    logic [8:0]    pv;
    d          = '0;
    pv         = p[8:0];
    d[1000:992] = pv;
    d[600]     = 1'b1;
    d[31:0]    = 32'hA000 + p;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  initial begin
    resetn          = 1'b0;
    enable_i        = 1'b0;
    bus.dsc_ready_i = 1'b0;
    bus.dsc_data_i  = '0;
    bus.eng_ready_i = '0;
    bus.eng_done_i  = '0;
    @(negedge clk); #1;
    chk("rst_valid", bus.eng_valid_o, 0);
    chk("rst_pull", bus.dsc_pull_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_dcnt", dispatch_cnt_o, 0);
    chk("rst_ccnt", done_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", bus.eng_data_o, 0);

    // Three descriptors, engines always ready: engines 0,1,2 in order
    @(negedge clk);
    resetn = 1'b1; enable_i = 1'b1; bus.eng_ready_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      bus.dsc_ready_i = 1'b1; bus.dsc_data_i = desc(5 + k); #1;
      chk("t1_pull", bus.dsc_pull_o, 1);
      @(negedge clk);
      bus.dsc_data_i = desc(6 + k); bus.dsc_ready_i = (k < 2); #1;
      chk("t1_arb_valid", bus.eng_valid_o, 0);
      chk("t1_arb_pull", bus.dsc_pull_o, 0);
      @(negedge clk);
      chk("t1_valid", bus.eng_valid_o, 1 << k);
      chk("t1_pasid", bus.eng_pasid_o, 5 + k);
      @(negedge clk);
      chk("t1_busy", busy_o, (1 << (k + 1)) - 1);
    end
    chk("t1_dcnt", dispatch_cnt_o, 3);
    chk("t1_nopull", bus.dsc_pull_o, 0);

    // Fill engine 3, then a 5th descriptor waits in ARB until engine 2 finishes
    bus.dsc_ready_i = 1'b1; bus.dsc_data_i = desc(8); #1;
    chk("t2_pull8", bus.dsc_pull_o, 1);
    @(negedge clk); bus.dsc_data_i = desc(9);
    @(negedge clk);
    chk("t2_valid8", bus.eng_valid_o, 4'b1000);
    chk("t2_pasid8", bus.eng_pasid_o, 8);
    @(negedge clk); #1;
    chk("t2_allbusy", busy_o, 4'b1111);
    chk("t2_pull9", bus.dsc_pull_o, 1);
    @(negedge clk); bus.dsc_ready_i = 1'b0; #1;
    chk("t2_arb_hold0", bus.eng_valid_o, 0);
    @(negedge clk);
    chk("t2_arb_hold1", bus.eng_valid_o, 0);
    chk("t2_arb_nopull", bus.dsc_pull_o, 0);
    @(negedge clk);
    chk("t2_arb_hold2", bus.eng_valid_o, 0);
    bus.eng_done_i = 4'b0100;
    @(negedge clk); bus.eng_done_i = 4'b0000;
    chk("t2_done_busy", busy_o, 4'b1011);
    chk("t2_done_cnt", done_cnt_o, 1);
    chk("t2_scan_lag", bus.eng_valid_o, 0);
    @(negedge clk);
    chk("t2_valid9", bus.eng_valid_o, 4'b0100);
    chk("t2_pasid9", bus.eng_pasid_o, 9);
    @(negedge clk);
    chk("t2_busy_after", busy_o, 4'b1111);
    chk("t2_dcnt", dispatch_cnt_o, 5);

    // Engine 1 stalls ready for 10 cycles; other engines' ready is ignored
    bus.eng_done_i = 4'b0010;
    @(negedge clk); bus.eng_done_i = 4'b0000;
    chk("t3_busy_pre", busy_o, 4'b1101);
    chk("t3_ccnt_pre", done_cnt_o, 2);
    bus.eng_ready_i = 4'b1101; bus.dsc_ready_i = 1'b1; bus.dsc_data_i = desc(10); #1;
    chk("t3_pull", bus.dsc_pull_o, 1);
    @(negedge clk); bus.dsc_data_i = desc(11);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_hold_valid", bus.eng_valid_o, 4'b0010);
      chk("t3_hold_data", bus.eng_data_o, desc(10));
      chk("t3_hold_nopull", bus.dsc_pull_o, 0);
      @(negedge clk);
    end
    chk("t3_still_valid", bus.eng_valid_o, 4'b0010);
    chk("t3_pasid", bus.eng_pasid_o, 10);
    bus.eng_ready_i = 4'b1111; bus.dsc_ready_i = 1'b0;
    @(negedge clk);
    chk("t3_busy", busy_o, 4'b1111);
    chk("t3_dcnt", dispatch_cnt_o, 6);
    chk("t3_valid_off", bus.eng_valid_o, 0);

    // Simultaneous dones, then a spurious done
    bus.eng_done_i = 4'b1001;
    @(negedge clk); bus.eng_done_i = 4'b0000;
    chk("t4_busy_0110", busy_o, 4'b0110);
    chk("t4_ccnt_pair", done_cnt_o, 4);
    bus.eng_done_i = 4'b0100;
    @(negedge clk); bus.eng_done_i = 4'b0000;
    chk("t4_busy_0010", busy_o, 4'b0010);
    chk("t4_ccnt5", done_cnt_o, 5);
    chk("t4_err_clear", err_o, 0);
    bus.eng_done_i = 4'b0100;
    @(negedge clk); bus.eng_done_i = 4'b0000;
    chk("t4_err_set", err_o, 1);
    chk("t4_ccnt_same", done_cnt_o, 5);
    chk("t4_busy_same", busy_o, 4'b0010);
    chk("t4_dcnt_same", dispatch_cnt_o, 6);

    // enable_i drops while in SEND: held descriptor still goes out, no new pull
    bus.eng_ready_i = 4'b0000; bus.dsc_ready_i = 1'b1; bus.dsc_data_i = desc(12); #1;
    chk("t5_pull", bus.dsc_pull_o, 1);
    @(negedge clk); bus.dsc_data_i = desc(13);
    @(negedge clk);
    chk("t5_valid", bus.eng_valid_o, 4'b0100);
    enable_i = 1'b0; bus.eng_ready_i = 4'b0100;
    @(negedge clk);
    chk("t5_nopull", bus.dsc_pull_o, 0);
    chk("t5_busy", busy_o, 4'b0110);
    chk("t5_dcnt", dispatch_cnt_o, 7);
    chk("t5_not_idle", idle_o, 0);
    bus.eng_done_i = 4'b0110;
    @(negedge clk); bus.eng_done_i = 4'b0000;
    chk("t5_busy0", busy_o, 0);
    chk("t5_ccnt", done_cnt_o, 7);
    chk("t5_idle", idle_o, 1);
    @(negedge clk);
    chk("t5_idle_hold", idle_o, 1);
    chk("t5_nopull_hold", bus.dsc_pull_o, 0);

    // Dispatch counter wrap from all-ones
    force dut.r_dispatch_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_dispatch_cnt;
    #1;
    chk("t6_preload", dispatch_cnt_o, 32'hFFFF_FFFF);
    enable_i = 1'b1; bus.eng_ready_i = 4'b1111; #1;
    chk("t6_pull", bus.dsc_pull_o, 1);
    @(negedge clk); bus.dsc_data_i = desc(14);
    @(negedge clk);
    chk("t6_valid3", bus.eng_valid_o, 4'b1000);
    @(negedge clk);
    chk("t6_wrap", dispatch_cnt_o, 0);
    chk("t6_busy", busy_o, 4'b1000);
    bus.eng_ready_i = 4'b0000;
    @(negedge clk); bus.dsc_ready_i = 1'b0;
    @(negedge clk);
    chk("t6_valid0", bus.eng_valid_o, 4'b0001);
    chk("t6_pasid14", bus.eng_pasid_o, 14);

    // Asynchronous reset mid-SEND
    #2 resetn = 1'b0;
    #1;
    chk("t7_valid", bus.eng_valid_o, 0);
    chk("t7_busy", busy_o, 0);
    chk("t7_idle", idle_o, 1);
    chk("t7_dcnt", dispatch_cnt_o, 0);
    chk("t7_ccnt", done_cnt_o, 0);
    chk("t7_err", err_o, 0);
    @(negedge clk); resetn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
